dpram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller placed directly in front of the team's dual-port RAM (WIDTH/ADDR parameterised, registered read data, write-priority per port).
- Port A of the RAM is the write port and port B the read port.
- Presents valid/ready streaming interfaces upstream and downstream, and hides the RAM's 1-cycle read latency behind a 2-entry output buffer.
- Sustains 1 word/cycle throughput.

---
 rtl/dpram_fifo_pkg.sv | 19 +
 rtl/fifo_out_buf.sv | 57 +++++
 rtl/dpram_fifo_ctrl.sv | 94 +++++++++
 tb/tb_dpram_fifo_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_fifo_pkg.sv
// Shared sizing for the dual-port-RAM FIFO controller: default widths,
// output-buffer depth and the depth helper used by controller and bench.
package dpram_fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_ADDR  = 4;
  localparam int OB_DEPTH   = 2;

  typedef logic [FIFO_ADDR:0] ptr_t;

  function automatic int depth_of(input int addr);
    return 1 << addr;
  endfunction

  function automatic int count_width(input int addr);
    return addr + 2;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer that absorbs the RAM's registered read data.
// Capture and pop may coincide; the head entry only moves on a pop.
module fifo_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_capture,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [1:0]       o_count,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_ent0;
  logic [WIDTH-1:0] r_ent1;
  logic [1:0]       r_cnt;
  logic             r_vld;
  logic [1:0]       w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_capture && !i_pop) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else if (!i_capture && i_pop) begin
      w_cnt_nxt = r_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_vld <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_vld <= (w_cnt_nxt != 2'd0);
    end
  end

  // Head is only rewritten when empty or when the current head leaves.
  always_ff @(posedge clk) begin
    if (i_pop && (r_cnt == 2'd2)) begin
      r_ent0 <= r_ent1;
    end else if (i_capture && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && i_pop))) begin
      r_ent0 <= i_data;
    end
    if (i_capture && (((r_cnt == 2'd1) && !i_pop) || ((r_cnt == 2'd2) && i_pop))) begin
      r_ent1 <= i_data;
    end
  end

  assign o_count = r_cnt;
  assign o_valid = r_vld;
  assign o_data  = r_ent0;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO controller in front of a dual-port RAM (A writes, B reads);
// push-to-output latency 3 cycles, 1 word/cycle sustained, s_ready low only when the RAM is full.
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int ADDR  = FIFO_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [ADDR+1:0]  count,
  output logic             ram_we_a,
  output logic [ADDR-1:0]  ram_addr_a,
  output logic [WIDTH-1:0] ram_din_a,
  output logic             ram_we_b,
  output logic [ADDR-1:0]  ram_addr_b,
  input  logic [WIDTH-1:0] ram_dout_b
);

  localparam logic [ADDR:0] C_DEPTH = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] C_ONE   = {{ADDR{1'b0}}, 1'b1};

  logic [ADDR:0] r_wr_ptr;
  logic [ADDR:0] r_rd_ptr;
  logic          r_inflight;
  logic [ADDR:0] w_occ;
  logic          w_ram_full;
  logic          w_ram_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [1:0]    w_ob_count;
  logic [2:0]    w_pending;
  logic [2:0]    w_limit;

  assign w_occ       = r_wr_ptr - r_rd_ptr;
  assign w_ram_full  = (w_occ == C_DEPTH);
  assign w_ram_empty = (w_occ == '0);

  assign s_ready = !rst && !w_ram_full;
  assign w_push  = s_valid && s_ready;
  assign w_pop   = m_valid && m_ready;

  // A pop this cycle frees a slot, so the next read may issue immediately.
  assign w_pending = {1'b0, w_ob_count} + {2'b00, r_inflight};
  assign w_limit   = 3'(OB_DEPTH) + {2'b00, w_pop};
  assign w_issue   = !w_ram_empty && (w_pending < w_limit);

  assign ram_we_a   = w_push;
  assign ram_addr_a = r_wr_ptr[ADDR-1:0];
  assign ram_din_a  = s_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = r_rd_ptr[ADDR-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_ONE;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + C_ONE;
      end
      r_inflight <= w_issue;
    end
  end

  fifo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .i_capture (r_inflight),
    .i_data    (ram_dout_b),
    .i_pop     (w_pop),
    .o_count   (w_ob_count),
    .o_valid   (m_valid),
    .o_data    (m_data)
  );

  assign count = {1'b0, w_occ}
               + {{(ADDR+1){1'b0}}, r_inflight}
               + {{ADDR{1'b0}}, w_ob_count};

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural dual-port RAM and a queue
// reference model of the stored words.
module tb_dpram_fifo_ctrl;

  localparam int WIDTH = 8;
  localparam int ADDR  = 4;
  localparam int DEPTH = dpram_fifo_pkg::depth_of(ADDR);

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [ADDR+1:0]  count;
  logic             ram_we_a;
  logic [ADDR-1:0]  ram_addr_a;
  logic [WIDTH-1:0] ram_din_a;
  logic             ram_we_b;
  logic [ADDR-1:0]  ram_addr_b;
  logic [WIDTH-1:0] ram_dout_b;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .count      (count),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
  );

  // Dual-port RAM: port A writes, port B registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [WIDTH-1:0] q[$];
  int               tq[$];

  logic             o_rdy, o_vld;
  logic [WIDTH-1:0] o_dat;
  logic [ADDR+1:0]  o_cnt;
  int               exp_size;
  logic [WIDTH-1:0] exp_front;
  int               exp_age;
  logic             acc, got;

  // One clock cycle: drive, sample mid-cycle, advance the model, move past the edge.
  task automatic tick(input logic sv, input logic [WIDTH-1:0] sd, input logic mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    rst     = 1'b0;
    #1;
    o_rdy = s_ready;
    o_vld = m_valid;
    o_dat = m_data;
    o_cnt = count;
    exp_size = q.size();
    if (exp_size > 0) begin
      exp_front = q[0];
      exp_age   = cyc - tq[0];
    end else begin
      exp_front = '0;
      exp_age   = -1;
    end
    acc = sv && o_rdy;
    got = o_vld && mr;
    if (got && exp_size > 0) begin
      void'(q.pop_front());
      void'(tq.pop_front());
    end
    if (acc) begin
      q.push_back(sd);
      tq.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b0;
    @(posedge clk); cyc++; #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready); end
    checks++; if (ram_we_a !== 1'b0) begin errors++; $display("FAIL reset_we_a: got %0b expected 0", ram_we_a); end
    checks++; if (ram_we_b !== 1'b0) begin errors++; $display("FAIL reset_we_b: got %0b expected 0", ram_we_b); end
    @(posedge clk); cyc++; #1;
    rst = 1'b0; s_valid = 1'b0;
    q.delete(); tq.delete();
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready: got %0b expected 1", s_ready); end
  endtask

  task automatic test_single();
    tick(1'b1, 8'hA5, 1'b1);
    checks++; if (!acc) begin errors++; $display("FAIL single_accept: got 0 expected 1"); end
    checks++; if (o_cnt !== '0) begin errors++; $display("FAIL single_count0: got %0d expected 0", o_cnt); end
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (k < 3) begin
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL single_early_valid: cycle N+%0d got %0b expected 0", k, o_vld); end
        checks++; if (o_cnt !== 6'd1) begin errors++; $display("FAIL single_count1: cycle N+%0d got %0d expected 1", k, o_cnt); end
      end else begin
        checks++; if (o_vld !== 1'b1 || o_dat !== 8'hA5) begin errors++; $display("FAIL single_latency: valid %0b data %0h expected 1 a5", o_vld, o_dat); end
      end
    end
    tick(1'b0, 8'h00, 1'b1);
    checks++; if (o_cnt !== '0 || o_vld !== 1'b0) begin errors++; $display("FAIL single_after_pop: count %0d valid %0b expected 0 0", o_cnt, o_vld); end
  endtask

  task automatic test_fill_drain();
    int nxt = 0;
    int nexp = 0;
    logic dropped = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick(nxt < 20, 8'(nxt), 1'b0);
      if (acc) nxt++;
      if (!o_rdy) dropped = 1'b1;
      if (dropped && c > 0) begin
        checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL fill_ready_reassert: cycle %0d got 1 expected 0", c); end
      end
    end
    checks++; if (nxt != 18) begin errors++; $display("FAIL fill_accepted: got %0d expected 18", nxt); end
    checks++; if (o_cnt !== 6'd18) begin errors++; $display("FAIL fill_count: got %0d expected 18", o_cnt); end
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (got) begin
        checks++; if (o_dat !== 8'(nexp)) begin errors++; $display("FAIL drain_order: got %0h expected %0h", o_dat, 8'(nexp)); end
        nexp++;
      end
    end
    checks++; if (nexp != 18) begin errors++; $display("FAIL drain_total: got %0d expected 18", nexp); end
    tick(1'b0, 8'h00, 1'b0);
    checks++; if (o_cnt !== '0) begin errors++; $display("FAIL drain_count: got %0d expected 0", o_cnt); end
  endtask

  task automatic test_back_to_back();
    int nxt = 0;
    int outs = 0;
    int first = -1;
    for (int c = 0; c < 130 && outs < 100; c++) begin
      tick(nxt < 100, 8'(nxt), 1'b1);
      if (nxt < 100) begin
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_drop: cycle %0d got 0 expected 1", c); end
      end
      if (acc) nxt++;
      if (o_vld) begin
        if (first < 0) first = c;
        checks++; if (o_dat !== 8'(outs)) begin errors++; $display("FAIL b2b_data: got %0h expected %0h", o_dat, 8'(outs)); end
        outs++;
      end else if (first >= 0) begin
        checks++; errors++; $display("FAIL b2b_gap: cycle %0d got valid 0 expected 1", c);
      end
    end
    checks++; if (first != 3) begin errors++; $display("FAIL b2b_latency: got %0d expected 3", first); end
    checks++; if (outs != 100) begin errors++; $display("FAIL b2b_total: got %0d expected 100", outs); end
  endtask

  task automatic test_random_stalls();
    int nxt = 0;
    int outs = 0;
    logic prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_dat = '0;
    logic sv, mr;
    for (int c = 0; c < 800 && outs < 40; c++) begin
      sv = (nxt < 40) && ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      tick(sv, 8'($urandom), mr);
      checks++; if (o_cnt !== 6'(exp_size)) begin errors++; $display("FAIL rand_count: got %0d expected %0d", o_cnt, exp_size); end
      if (o_vld) begin
        checks++;
        if (exp_size == 0) begin errors++; $display("FAIL rand_spurious_valid: got valid 1 expected 0"); end
        else if (o_dat !== exp_front) begin errors++; $display("FAIL rand_order: got %0h expected %0h", o_dat, exp_front); end
      end else if (exp_age >= 3) begin
        checks++; errors++; $display("FAIL rand_late_valid: head age %0d got valid 0 expected 1", exp_age);
      end
      if (prev_stall) begin
        checks++; if (o_vld !== 1'b1 || o_dat !== prev_dat) begin errors++; $display("FAIL rand_stall_stable: got %0b/%0h expected 1/%0h", o_vld, o_dat, prev_dat); end
      end
      prev_stall = o_vld && !mr;
      prev_dat   = o_dat;
      if (acc) nxt++;
      if (got) outs++;
    end
    checks++; if (outs != 40) begin errors++; $display("FAIL rand_total: got %0d expected 40", outs); end
  endtask

  task automatic test_reset_mid_read();
    int nouts = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0 || ram_we_a !== 1'b0) begin errors++; $display("FAIL midrst_gate: s_ready %0b we_a %0b expected 0 0", s_ready, ram_we_a); end
    @(posedge clk); cyc++; #1;
    q.delete(); tq.delete();
    tick(1'b0, 8'h00, 1'b0);
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b expected 0", o_vld); end
    checks++; if (o_cnt !== '0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", o_cnt); end
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b expected 1", o_rdy); end
    tick(1'b1, 8'h3C, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (got) begin
        checks++;
        if (nouts == 0 && o_dat !== 8'h3C) begin errors++; $display("FAIL midrst_first: got %0h expected 3c", o_dat); end
        else if (nouts > 0) begin errors++; $display("FAIL midrst_stale: got %0h expected none", o_dat); end
        nouts++;
      end
    end
    checks++; if (nouts != 1) begin errors++; $display("FAIL midrst_total: got %0d expected 1", nouts); end
  endtask

  task automatic test_full_pop();
    int nxt = 0;
    int outs = 0;
    logic [WIDTH-1:0] last = '0;
    for (int c = 0; c < 30; c++) begin
      tick(nxt < 18, 8'(8'h40 + nxt), 1'b0);
      if (acc) nxt++;
    end
    tick(1'b1, 8'hEE, 1'b0);
    checks++; if (o_rdy !== 1'b0 || o_cnt !== 6'd18) begin errors++; $display("FAIL full_state: ready %0b count %0d expected 0 18", o_rdy, o_cnt); end
    tick(1'b1, 8'hEE, 1'b1);
    checks++; if (o_rdy !== 1'b0 || !got) begin errors++; $display("FAIL full_pop_cycle: ready %0b pop %0b expected 0 1", o_rdy, got); end
    tick(1'b1, 8'hEE, 1'b0);
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %0b expected 1", o_rdy); end
    checks++; if (o_cnt !== 6'd17) begin errors++; $display("FAIL full_count_mid: got %0d expected 17", o_cnt); end
    tick(1'b0, 8'h00, 1'b0);
    checks++; if (o_cnt !== 6'd18 || o_rdy !== 1'b0) begin errors++; $display("FAIL full_refill: count %0d ready %0b expected 18 0", o_cnt, o_rdy); end
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (got) begin
        checks++; if (o_dat !== exp_front) begin errors++; $display("FAIL full_drain_order: got %0h expected %0h", o_dat, exp_front); end
        last = o_dat;
        outs++;
      end
    end
    checks++; if (outs != 18 || last !== 8'hEE) begin errors++; $display("FAIL full_drain_tail: count %0d last %0h expected 18 ee", outs, last); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_random_stalls();
    test_reset_mid_read();
    test_full_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
